axi_wr_arbiter: RTL and testbench



---
 rtl/axi_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI write master.
// Each requester sees a private start/ready/writing/done handshake. The
// winner's address and length are latched at grant time, its data is steered
// to the master, and the master's writing/done strobes are routed back to it.
module axi_wr_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_start,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              req0_writing,
    output logic              req0_done,
    input  logic              req1_start,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              req1_writing,
    output logic              req1_done,
    output logic              m_start,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              m_writing,
    input  logic              m_done,
    output logic [CNT_W-1:0]  burst_cnt0,
    output logic [CNT_W-1:0]  burst_cnt1
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [1:0] state;
    logic       grant;      // requester currently owning the master
    logic       last;       // requester served most recently
    logic       win;        // requester that would be granted this cycle
    logic       any_start;
    logic       active;     // a burst is in flight (ISSUE or BUSY)

    // Completed-burst counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Winner selection: a lone request wins; under contention the requester
    // not served last wins, which gives strict alternation.
    always_comb begin
        any_start = req0_start | req1_start;
        if (req0_start && req1_start) begin
            win = ~last;
        end else begin
            win = req1_start;
        end
    end

    // Grant FSM, latched burst parameters, done pulses and burst counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            m_start    <= 1'b0;
            m_addr     <= '0;
            m_len      <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            burst_cnt0 <= '0;
            burst_cnt1 <= '0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The master must be idle before a new burst is handed over.
                    if (m_ready && any_start) begin
                        grant   <= win;
                        m_addr  <= win ? req1_addr : req0_addr;
                        m_len   <= win ? req1_len  : req0_len;
                        m_start <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Master dropping ready means it has accepted the start.
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_done) begin
                        if (grant) begin
                            req1_done  <= 1'b1;
                            burst_cnt1 <= sat_inc(burst_cnt1);
                        end else begin
                            req0_done  <= 1'b1;
                            burst_cnt0 <= sat_inc(burst_cnt0);
                        end
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: begin
                    m_start <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency steering of ready, writing and data by the current grant.
    assign active       = (state == ISSUE) || (state == BUSY);
    assign req0_ready   = !((state != IDLE) && !grant);
    assign req1_ready   = !((state != IDLE) && grant);
    assign req0_writing = m_writing && active && !grant;
    assign req1_writing = m_writing && active && grant;
    assign m_data       = grant ? req1_data : req0_data;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: a vector table for the first
// single-requester burst, then scoreboard-driven bursts for contention,
// late arrival, reset mid-burst and counter saturation.
module tb_axi_wr_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic [1:0]        st;
    logic [ADDR_W-1:0] a0, a1;
    logic [LEN_W-1:0]  l0, l1;
    logic [DATA_W-1:0] d0, d1;
    logic              mr, mw, md;
    logic              req0_ready, req0_writing, req0_done;
    logic              req1_ready, req1_writing, req1_done;
    logic              m_start;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  burst_cnt0, burst_cnt1;

    int passed = 0;
    int total  = 0;
    int m0 = 0;
    int m1 = 0;

    typedef struct packed {
        logic s0, s1, mr, mw, md;
        logic r0, r1, w0, w1, ms, dn0, dn1;
    } vec_t;
    vec_t tbl[15];

    typedef struct packed {
        logic              g;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } sb_t;
    sb_t sbq[$];

    axi_wr_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_start(st[0]), .req0_addr(a0), .req0_len(l0), .req0_data(d0),
        .req0_ready(req0_ready), .req0_writing(req0_writing), .req0_done(req0_done),
        .req1_start(st[1]), .req1_addr(a1), .req1_len(l1), .req1_data(d1),
        .req1_ready(req1_ready), .req1_writing(req1_writing), .req1_done(req1_done),
        .m_start(m_start), .m_addr(m_addr), .m_len(m_len), .m_data(m_data),
        .m_ready(mr), .m_writing(mw), .m_done(md),
        .burst_cnt0(burst_cnt0), .burst_cnt1(burst_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input logic g);
        return g ? req1_ready : req0_ready;
    endfunction

    function automatic logic wr(input logic g);
        return g ? req1_writing : req0_writing;
    endfunction

    function automatic logic dn(input logic g);
        return g ? req1_done : req0_done;
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
    endfunction

    task automatic push(input logic g);
        sb_t e;
        e.g    = g;
        e.addr = g ? a1 : a0;
        e.len  = g ? l1 : l0;
        sbq.push_back(e);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        st = 2'b00;
        mw = 1'b0;
        md = 1'b0;
        #1;
        chk("rst_m_start", 64'(m_start), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd1);
        chk("rst_ready1", 64'(req1_ready), 64'd1);
        chk("rst_cnt0", 64'(burst_cnt0), 64'd0);
        chk("rst_cnt1", 64'(burst_cnt1), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        cyc();
        rst_n = 1'b1;
        mr = 1'b1;
        m0 = 0;
        m1 = 0;
    endtask

    // Plays the AXI master for one burst: waits for m_start, checks the grant
    // against the scoreboard, streams len+1 beats, then returns done.
    task automatic service(input bit drop, input bit late1);
        sb_t e;
        bit ok;
        logic [ADDR_W-1:0] saved;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk("grant_seen", 64'(ok), 64'd1);
        if (!ok) return;
        chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk("grant_addr", 64'(m_addr), 64'(e.addr));
        chk("grant_len", 64'(m_len), 64'(e.len));
        chk("ready_granted", 64'(rdy(e.g)), 64'd0);
        chk("ready_other", 64'(rdy(!e.g)), 64'd1);
        if (drop) st[e.g] = 1'b0;
        mr = 1'b0;
        cyc();
        chk("m_start_busy", 64'(m_start), 64'd0);
        saved = e.g ? a1 : a0;
        if (e.g) a1 = ~a1; else a0 = ~a0;
        for (int n = 0; n <= int'(e.len); n++) begin
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            mw = 1'b1;
            if (late1 && n == 0) begin
                st[1] = 1'b1;
                push(1'b1);
            end
            #1;
            chk("wr_granted", 64'(wr(e.g)), 64'd1);
            chk("wr_other", 64'(wr(!e.g)), 64'd0);
            chk("m_data", m_data, e.g ? d1 : d0);
            chk("addr_held", 64'(m_addr), 64'(e.addr));
            if (late1) chk("late_ready1", 64'(req1_ready), 64'd1);
            cyc();
        end
        if (e.g) a1 = saved; else a0 = saved;
        mw = 1'b0;
        md = 1'b1;
        cyc();
        md = 1'b0;
        if (e.g) m1 = sat(m1); else m0 = sat(m0);
        #1;
        chk("done_granted", 64'(dn(e.g)), 64'd1);
        chk("done_other", 64'(dn(!e.g)), 64'd0);
        chk("cnt0", 64'(burst_cnt0), 64'(m0));
        chk("cnt1", 64'(burst_cnt1), 64'(m1));
        cyc();
        chk("done_one_wide", 64'(dn(e.g)), 64'd0);
        chk("no_grant_mready_low", 64'(m_start), 64'd0);
        mr = 1'b1;
    endtask

    initial begin
        // inputs: s0 s1 mr mw md | expected: r0 r1 w0 w1 ms dn0 dn1
        tbl[0]  = 12'b10000_1100000;   // m_ready low in IDLE: no grant
        tbl[1]  = 12'b10100_1100000;   // grant taken on this edge
        tbl[2]  = 12'b00000_0100100;   // ISSUE, master accepts
        for (int i = 3; i <= 10; i++) tbl[i] = 12'b00010_0110000;
        tbl[11] = 12'b00001_0100000;   // m_done in BUSY
        tbl[12] = 12'b00100_1100010;   // done pulse, back in IDLE
        tbl[13] = 12'b00111_1100000;   // spurious writing/done in IDLE
        tbl[14] = 12'b00100_1100000;   // no pulse from the spurious done

        rst_n = 1'b0;
        st = 2'b00;
        a0 = 30'h100; l0 = 8'd7; a1 = 30'h3000; l1 = 8'd1;
        d0 = '0; d1 = '0;
        mr = 1'b1; mw = 1'b0; md = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_start", 64'(m_start), 64'd0);
        chk("reset_m_addr", 64'(m_addr), 64'd0);
        chk("reset_m_len", 64'(m_len), 64'd0);
        chk("reset_ready0", 64'(req0_ready), 64'd1);
        chk("reset_ready1", 64'(req1_ready), 64'd1);
        chk("reset_done0", 64'(req0_done), 64'd0);
        chk("reset_cnt0", 64'(burst_cnt0), 64'd0);
        chk("reset_cnt1", 64'(burst_cnt1), 64'd0);
        rst_n = 1'b1;

        // Single requester burst, one vector per cycle.
        for (int i = 0; i < 15; i++) begin
            st[0] = tbl[i].s0; st[1] = tbl[i].s1;
            mr = tbl[i].mr; mw = tbl[i].mw; md = tbl[i].md;
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            #2;
            chk($sformatf("tbl%0d_ready0", i), 64'(req0_ready), 64'(tbl[i].r0));
            chk($sformatf("tbl%0d_ready1", i), 64'(req1_ready), 64'(tbl[i].r1));
            chk($sformatf("tbl%0d_wr0", i), 64'(req0_writing), 64'(tbl[i].w0));
            chk($sformatf("tbl%0d_wr1", i), 64'(req1_writing), 64'(tbl[i].w1));
            chk($sformatf("tbl%0d_m_start", i), 64'(m_start), 64'(tbl[i].ms));
            chk($sformatf("tbl%0d_done0", i), 64'(req0_done), 64'(tbl[i].dn0));
            chk($sformatf("tbl%0d_done1", i), 64'(req1_done), 64'(tbl[i].dn1));
            chk($sformatf("tbl%0d_m_data", i), m_data, d0);
            if (tbl[i].ms) begin
                chk($sformatf("tbl%0d_m_addr", i), 64'(m_addr), 64'h100);
                chk($sformatf("tbl%0d_m_len", i), 64'(m_len), 64'd7);
            end
            @(posedge clk);
            #1;
        end
        chk("tbl_cnt0", 64'(burst_cnt0), 64'd1);
        chk("tbl_cnt1", 64'(burst_cnt1), 64'd0);

        // Contention from reset: strict alternation 0,1,0,1.
        pulse_reset();
        a0 = 30'h200; l0 = 8'd3;
        a1 = 30'h300; l1 = 8'd5;
        st = 2'b11;
        push(1'b0); push(1'b1); push(1'b0); push(1'b1);
        for (int k = 0; k < 4; k++) service(1'b0, 1'b0);

        // Fifth burst goes to requester 0; reset it while busy.
        cyc();
        chk("fifth_m_start", 64'(m_start), 64'd1);
        chk("fifth_ready0", 64'(req0_ready), 64'd0);
        mr = 1'b0;
        cyc();
        pulse_reset();

        // After reset mid-burst, requester 0 wins first again.
        st = 2'b11;
        push(1'b0); push(1'b1);
        service(1'b1, 1'b0);
        service(1'b1, 1'b0);

        // Late arrival of requester 1 during a requester-0 burst.
        a0 = 30'h400; l0 = 8'd2;
        st[0] = 1'b1;
        push(1'b0);
        service(1'b1, 1'b1);
        cyc();
        chk("late_grant_latency", 64'(m_start), 64'd1);
        chk("late_grant_ready1", 64'(req1_ready), 64'd0);
        service(1'b1, 1'b0);

        // Saturation of burst_cnt1.
        l1 = 8'd0;
        for (int k = 0; k < 16; k++) begin
            st[1] = 1'b1;
            push(1'b1);
            service(1'b1, 1'b0);
        end
        chk("cnt1_saturated", 64'(burst_cnt1), 64'hF);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
